// File: rtl/i2c_target_mem.sv
// i2c_target_mem: I2C-style serial target backed by a small register array.
// One frame moves exactly one data byte: START, register address, R/W bit,
// target ACK, one data byte, ACK slot, then STOP or a repeated START.
// scl/sda are oversampled on clk through two-flop synchronisers; a third
// flop per line gives the edge detectors.
module i2c_target_mem #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scl,
  inout  wire                  sda,
  output logic                 busy,
  output logic                 wr_strobe,
  output logic                 rd_strobe,
  output logic [ADDRWIDTH-1:0] last_addr
);

  localparam int DEPTH = 2 ** ADDRWIDTH;
  localparam int MAXW  = (DATAWIDTH > ADDRWIDTH) ? DATAWIDTH : ADDRWIDTH;
  localparam int CNT_W = $clog2(MAXW + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDRWIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATAWIDTH - 1);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_RW        = 4'd2,
    ST_AACK      = 4'd3,
    ST_WDATA     = 4'd4,
    ST_WACK      = 4'd5,
    ST_RDATA     = 4'd6,
    ST_RACK      = 4'd7,
    ST_WAIT_STOP = 4'd8
  } state_t;

  state_t state_r;
  state_t next_state_s;

  // synchroniser and edge-detect flops
  logic scl_s1_r, scl_s2_r, scl_s3_r;
  logic sda_s1_r, sda_s2_r, sda_s3_r;

  // bus events, each a single-clk pulse
  logic scl_rise_s, scl_fall_s, start_s, stop_s;

  // datapath
  logic [CNT_W-1:0]     bit_cnt_r;
  logic [ADDRWIDTH-1:0] addr_r;
  logic [DATAWIDTH-1:0] shift_r;
  logic                 rw_r;
  logic                 ack_phase_r;
  logic [DATAWIDTH-1:0] mem_r [DEPTH];

  logic                 addr_done_s;
  logic                 data_done_s;
  logic [DATAWIDTH-1:0] rd_byte_s;
  logic [DATAWIDTH-1:0] wr_byte_s;

  // registered outputs and their next values
  logic                 sda_oe_r,    sda_oe_nxt_s;
  logic                 busy_r,      busy_nxt_s;
  logic                 wr_strobe_r, wr_strobe_nxt_s;
  logic                 rd_strobe_r, rd_strobe_nxt_s;
  logic [ADDRWIDTH-1:0] last_addr_r, last_addr_nxt_s;

  // Open-drain: only ever pull low or float.
  assign sda       = sda_oe_r ? 1'b0 : 1'bz;
  assign busy      = busy_r;
  assign wr_strobe = wr_strobe_r;
  assign rd_strobe = rd_strobe_r;
  assign last_addr = last_addr_r;

  // START/STOP require scl high on both sides of the sda transition.
  assign scl_rise_s = scl_s2_r & ~scl_s3_r;
  assign scl_fall_s = ~scl_s2_r & scl_s3_r;
  assign start_s    = scl_s2_r & scl_s3_r & sda_s3_r & ~sda_s2_r;
  assign stop_s     = scl_s2_r & scl_s3_r & ~sda_s3_r & sda_s2_r;

  assign addr_done_s = (bit_cnt_r == ADDR_LAST);
  assign data_done_s = (bit_cnt_r == DATA_LAST);
  assign rd_byte_s   = mem_r[addr_r];
  assign wr_byte_s   = {shift_r[DATAWIDTH-2:0], sda_s2_r};

  // Synchronise scl/sda into clk; reset value models an idle (high) bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_s1_r <= 1'b1;
      scl_s2_r <= 1'b1;
      scl_s3_r <= 1'b1;
      sda_s1_r <= 1'b1;
      sda_s2_r <= 1'b1;
      sda_s3_r <= 1'b1;
    end else begin
      scl_s1_r <= scl;
      scl_s2_r <= scl_s1_r;
      scl_s3_r <= scl_s2_r;
      sda_s1_r <= sda;
      sda_s2_r <= sda_s1_r;
      sda_s3_r <= sda_s2_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; START/STOP override every state.
  always_comb begin
    next_state_s = state_r;
    if (start_s) begin
      next_state_s = ST_ADDR;
    end else if (stop_s) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          next_state_s = ST_IDLE;
        end
        ST_ADDR: begin
          if (scl_rise_s && addr_done_s) next_state_s = ST_RW;
          else                           next_state_s = ST_ADDR;
        end
        ST_RW: begin
          if (scl_rise_s) next_state_s = ST_AACK;
          else            next_state_s = ST_RW;
        end
        ST_AACK: begin
          if (scl_fall_s && ack_phase_r) begin
            if (rw_r) next_state_s = ST_RDATA;
            else      next_state_s = ST_WDATA;
          end else begin
            next_state_s = ST_AACK;
          end
        end
        ST_WDATA: begin
          if (scl_rise_s && data_done_s) next_state_s = ST_WACK;
          else                           next_state_s = ST_WDATA;
        end
        ST_WACK: begin
          if (scl_fall_s && ack_phase_r) next_state_s = ST_WAIT_STOP;
          else                           next_state_s = ST_WACK;
        end
        ST_RDATA: begin
          if (scl_fall_s && data_done_s) next_state_s = ST_RACK;
          else                           next_state_s = ST_RDATA;
        end
        ST_RACK: begin
          if (scl_rise_s) next_state_s = ST_WAIT_STOP;
          else            next_state_s = ST_RACK;
        end
        ST_WAIT_STOP: begin
          next_state_s = ST_WAIT_STOP;
        end
        default: begin
          next_state_s = ST_IDLE;
        end
      endcase
    end
  end

  // FSM output decode: next sda drive, strobes, busy and last_addr.
  always_comb begin
    sda_oe_nxt_s    = sda_oe_r;
    busy_nxt_s      = busy_r;
    wr_strobe_nxt_s = 1'b0;
    rd_strobe_nxt_s = 1'b0;
    last_addr_nxt_s = last_addr_r;
    if (start_s) begin
      sda_oe_nxt_s = 1'b0;
      busy_nxt_s   = 1'b1;
    end else if (stop_s) begin
      sda_oe_nxt_s = 1'b0;
      busy_nxt_s   = 1'b0;
    end else begin
      case (state_r)
        ST_AACK: begin
          // first falling edge starts the ACK pulse, second one ends it
          if (scl_fall_s) begin
            if (!ack_phase_r) begin
              sda_oe_nxt_s = 1'b1;
            end else if (rw_r) begin
              sda_oe_nxt_s    = ~rd_byte_s[DATAWIDTH-1];
              rd_strobe_nxt_s = 1'b1;
              last_addr_nxt_s = addr_r;
            end else begin
              sda_oe_nxt_s = 1'b0;
            end
          end else begin
            sda_oe_nxt_s = sda_oe_r;
          end
        end
        ST_WDATA: begin
          sda_oe_nxt_s = 1'b0;
          if (scl_rise_s && data_done_s) begin
            wr_strobe_nxt_s = 1'b1;
            last_addr_nxt_s = addr_r;
          end else begin
            wr_strobe_nxt_s = 1'b0;
          end
        end
        ST_WACK: begin
          if (scl_fall_s) sda_oe_nxt_s = ~ack_phase_r;
          else            sda_oe_nxt_s = sda_oe_r;
        end
        ST_RDATA: begin
          // shift_r still holds the bit just sent in its MSB
          if (scl_fall_s) begin
            if (data_done_s) sda_oe_nxt_s = 1'b0;
            else             sda_oe_nxt_s = ~shift_r[DATAWIDTH-2];
          end else begin
            sda_oe_nxt_s = sda_oe_r;
          end
        end
        default: begin
          sda_oe_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Register the decoded outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sda_oe_r    <= 1'b0;
      busy_r      <= 1'b0;
      wr_strobe_r <= 1'b0;
      rd_strobe_r <= 1'b0;
      last_addr_r <= {ADDRWIDTH{1'b0}};
    end else begin
      sda_oe_r    <= sda_oe_nxt_s;
      busy_r      <= busy_nxt_s;
      wr_strobe_r <= wr_strobe_nxt_s;
      rd_strobe_r <= rd_strobe_nxt_s;
      last_addr_r <= last_addr_nxt_s;
    end
  end

  // Datapath: bit counter, address/data shifting and the register array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_r   <= CNT_ZERO;
      addr_r      <= {ADDRWIDTH{1'b0}};
      shift_r     <= {DATAWIDTH{1'b0}};
      rw_r        <= 1'b0;
      ack_phase_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATAWIDTH{1'b0}};
      end
    end else if (start_s || stop_s) begin
      // abandon whatever was in flight; nothing partial is committed
      bit_cnt_r   <= CNT_ZERO;
      ack_phase_r <= 1'b0;
    end else begin
      case (state_r)
        ST_ADDR: begin
          if (scl_rise_s) begin
            addr_r    <= {addr_r[ADDRWIDTH-2:0], sda_s2_r};
            bit_cnt_r <= addr_done_s ? CNT_ZERO : (bit_cnt_r + CNT_ONE);
          end
        end
        ST_RW: begin
          if (scl_rise_s) begin
            rw_r <= sda_s2_r;
          end
        end
        ST_AACK: begin
          if (scl_fall_s) begin
            if (!ack_phase_r) begin
              ack_phase_r <= 1'b1;
            end else begin
              ack_phase_r <= 1'b0;
              bit_cnt_r   <= CNT_ZERO;
              if (rw_r) begin
                shift_r <= rd_byte_s;
              end
            end
          end
        end
        ST_WDATA: begin
          if (scl_rise_s) begin
            shift_r <= wr_byte_s;
            if (data_done_s) begin
              mem_r[addr_r] <= wr_byte_s;
              bit_cnt_r     <= CNT_ZERO;
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_ONE;
            end
          end
        end
        ST_WACK: begin
          if (scl_fall_s) begin
            ack_phase_r <= ~ack_phase_r;
          end
        end
        ST_RDATA: begin
          if (scl_fall_s) begin
            if (data_done_s) begin
              bit_cnt_r <= CNT_ZERO;
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_ONE;
              shift_r   <= {shift_r[DATAWIDTH-2:0], 1'b0};
            end
          end
        end
        default: begin
          bit_cnt_r <= bit_cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_mem.sv
// tb_i2c_target_mem: bus-controller model driving scl/sda, with a strobe
// scoreboard and a received-byte scoreboard fed from queues of expectations.
module tb_i2c_target_mem;

  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic          scl_drv;
  logic          sda_low;
  wire           sda;
  logic          busy;
  logic          wr_strobe;
  logic          rd_strobe;
  logic [AW-1:0] last_addr;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_target_mem #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl_drv),
    .sda       (sda),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .rd_strobe (rd_strobe),
    .last_addr (last_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          is_rd;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] exp_byte_q[$];
  exp_t          mon_e;
  logic [DW-1:0] mon_b;
  logic [DW-1:0] rx_byte;
  event          rx_ev;
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_wr_seen = 0;
  int            busy_drops = 0;
  logic          hold_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // strobe scoreboard
  always @(negedge clk) begin
    if (wr_strobe || rd_strobe) begin
      if (wr_strobe) n_wr_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL strobe_unexpected: got wr=%0b rd=%0b addr=%0d, expected none",
                 wr_strobe, rd_strobe, last_addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("strobe_rd", {31'd0, rd_strobe}, {31'd0, mon_e.is_rd});
        chk("strobe_wr", {31'd0, wr_strobe}, {31'd0, ~mon_e.is_rd});
        chk("strobe_addr", {26'd0, last_addr}, {26'd0, mon_e.addr});
      end
    end
  end

  // received-byte scoreboard
  always @(rx_ev) begin
    if (exp_byte_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL rx_unexpected: got %0h, expected none", rx_byte);
    end else begin
      mon_b = exp_byte_q.pop_front();
      chk("rx_byte", {24'd0, rx_byte}, {24'd0, mon_b});
    end
  end

  always @(negedge busy) begin
    if (hold_busy) busy_drops++;
  end

  task automatic wait_q();
    repeat (8) @(negedge clk);
  endtask

  // one scl period with scl low on entry and exit; sample mid-high
  task automatic xfer_bit(input logic tx, output logic rx);
    sda_low = ~tx;
    wait_q();
    scl_drv = 1'b1;
    wait_q();
    rx = sda;
    wait_q();
    scl_drv = 1'b0;
    wait_q();
  endtask

  task automatic do_stop();
    sda_low = 1'b1;
    wait_q();
    scl_drv = 1'b1;
    wait_q();
    sda_low = 1'b0;
    wait_q();
  endtask

  // START (bus idle) or repeated START (scl low), address, R/W, target ACK
  task automatic header(input logic [AW-1:0] addr, input logic rw, input logic rep);
    logic r;
    if (rep) begin
      sda_low = 1'b0;
      wait_q();
      scl_drv = 1'b1;
      wait_q();
    end
    sda_low = 1'b1;
    wait_q();
    scl_drv = 1'b0;
    wait_q();
    for (int i = AW - 1; i >= 0; i--) xfer_bit(addr[i], r);
    xfer_bit(rw, r);
    xfer_bit(1'b1, r);
    chk("aack_low", {31'd0, r}, 32'd0);
  endtask

  task automatic write_frame(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic rep, input logic stop);
    logic r;
    exp_q.push_back('{is_rd: 1'b0, addr: addr});
    header(addr, 1'b0, rep);
    for (int i = DW - 1; i >= 0; i--) xfer_bit(data[i], r);
    xfer_bit(1'b1, r);
    chk("wack_low", {31'd0, r}, 32'd0);
    if (stop) do_stop();
  endtask

  task automatic read_frame(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic rep, input logic stop);
    logic r;
    exp_q.push_back('{is_rd: 1'b1, addr: addr});
    exp_byte_q.push_back(data);
    header(addr, 1'b1, rep);
    for (int i = DW - 1; i >= 0; i--) begin
      xfer_bit(1'b1, r);
      rx_byte[i] = r;
    end
    ->rx_ev;
    xfer_bit(1'b1, r);
    chk("rack_released", {31'd0, r}, 32'd1);
    if (stop) do_stop();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int wr_before;
    logic r;
    reset   = 1'b1;
    scl_drv = 1'b1;
    sda_low = 1'b0;
    rx_byte = 8'h00;
    repeat (4) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sda", {31'd0, sda}, 32'd1);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_wr", {31'd0, wr_strobe}, 32'd0);
    chk("rst_rd", {31'd0, rd_strobe}, 32'd0);
    chk("rst_last_addr", {26'd0, last_addr}, 32'd0);

    // write 0x9B to 13
    write_frame(6'd13, 8'h9B, 1'b0, 1'b0);
    chk("wr_busy_before_stop", {31'd0, busy}, 32'd1);
    chk("wr_last_addr", {26'd0, last_addr}, 32'd13);
    do_stop();
    chk("wr_busy_after_stop", {31'd0, busy}, 32'd0);

    // read back 13, then an unwritten address 19
    read_frame(6'd13, 8'h9B, 1'b0, 1'b1);
    read_frame(6'd19, 8'h00, 1'b0, 1'b1);
    chk("rd19_last_addr", {26'd0, last_addr}, 32'd19);

    // write to 5 aborted by STOP after 4 data bits
    wr_before = n_wr_seen;
    header(6'd5, 1'b0, 1'b0);
    xfer_bit(1'b1, r);
    xfer_bit(1'b0, r);
    xfer_bit(1'b1, r);
    xfer_bit(1'b1, r);
    do_stop();
    repeat (4) @(negedge clk);
    chk("abort_no_wr", wr_before, n_wr_seen);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    read_frame(6'd5, 8'h00, 1'b0, 1'b1);

    // write 2, repeated START, read 2 with no STOP in between
    hold_busy = 1'b1;
    write_frame(6'd2, 8'h5A, 1'b0, 1'b0);
    read_frame(6'd2, 8'h5A, 1'b1, 1'b0);
    chk("rs_busy_held", {31'd0, busy}, 32'd1);
    hold_busy = 1'b0;
    chk("rs_busy_drops", busy_drops, 0);
    do_stop();

    // reset while the target drives a 0 data bit (0x5A MSB)
    exp_q.push_back('{is_rd: 1'b1, addr: 6'd2});
    header(6'd2, 1'b1, 1'b0);
    chk("rdata_drives0", {31'd0, sda}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_mid_sda", {31'd0, sda}, 32'd1);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_last_addr", {26'd0, last_addr}, 32'd0);
    wait_q();
    do_stop();

    // normal traffic afterwards; reset cleared the array
    write_frame(6'd7, 8'hC3, 1'b0, 1'b1);
    read_frame(6'd7, 8'hC3, 1'b0, 1'b1);
    read_frame(6'd13, 8'h00, 1'b0, 1'b1);

    repeat (10) @(negedge clk);
    chk("strobe_q_drained", exp_q.size(), 0);
    chk("byte_q_drained", exp_byte_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
